// File: rtl/chan_fifo_pkg.sv
// Shared types for the typed multi-channel FIFO with packet-aware round-robin merge.
package chan_fifo_pkg;

  typedef enum logic [1:0] {
    K_DATA = 2'd0,
    K_LAST = 2'd1,
    K_CMD  = 2'd2,
    K_RSVD = 2'd3
  } kind_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam logic [1:0] KIND_RSVD = 2'd3;

  function automatic int wrap_inc(input int c, input int n);
    return (c + 1 >= n) ? 0 : c + 1;
  endfunction

endpackage

// File: rtl/chan_fifo_lane.sv
// Single-channel FIFO; head entry is read combinationally so the merge path needs no extra cycle.
module chan_fifo_lane #(
  parameter int EW    = 10,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [EW-1:0]           wdata,
  output logic [EW-1:0]           rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign level = r_wr_ptr - r_rd_ptr;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/typed_chan_arb_fifo.sv
// Per-channel FIFOs of typed beats merged onto one stream by a round-robin arbiter
// that keeps a channel granted from the first beat of a packet until its terminator.
module typed_chan_arb_fifo
  import chan_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [CHANNELS-1:0]                     in_valid,
  output logic [CHANNELS-1:0]                     in_ready,
  input  logic [2*CHANNELS-1:0]                   in_kind,
  input  logic [WIDTH*CHANNELS-1:0]               in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [1:0]                              out_kind,
  output logic [WIDTH-1:0]                        out_data,
  output logic [$clog2(CHANNELS)-1:0]             out_chan,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0]     level,
  output logic                                    err
);

  localparam int CW = $clog2(CHANNELS);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    kind_t            kind;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic [CHANNELS-1:0] w_full;
  logic [CHANNELS-1:0] w_empty;
  logic [CHANNELS-1:0] w_push;
  logic [CHANNELS-1:0] w_pop;
  logic [CHANNELS-1:0] w_rsvd_acc;
  logic [EW-1:0]       w_head [CHANNELS];

  arb_state_t          r_state;
  logic [CW-1:0]       r_rr_ptr;
  logic [CW-1:0]       r_lock_chan;
  logic [CW-1:0]       r_held_chan;
  logic                r_held;
  logic                r_err;

  logic [CW-1:0]       w_grant;
  logic                w_found;
  logic                w_out_valid;
  logic                w_hs;
  entry_t              w_sel;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      typedef logic [AW:0] ptr_t;

      ptr_t   w_lvl;
      entry_t w_wentry;
      logic   w_rsvd;

      assign w_rsvd          = (in_kind[2*gi +: 2] == KIND_RSVD);
      assign w_wentry.kind   = kind_t'(in_kind[2*gi +: 2]);
      assign w_wentry.data   = in_data[WIDTH*gi +: WIDTH];
      assign in_ready[gi]    = !rst && !w_full[gi];
      // Reserved beats complete the handshake but are dropped instead of stored.
      assign w_push[gi]      = in_valid[gi] && in_ready[gi] && !w_rsvd;
      assign w_rsvd_acc[gi]  = in_valid[gi] && in_ready[gi] && w_rsvd;
      assign w_pop[gi]       = w_hs && (w_grant == CW'(gi));

      chan_fifo_lane #(
        .EW    (EW),
        .DEPTH (DEPTH)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[gi]),
        .pop   (w_pop[gi]),
        .wdata (w_wentry),
        .rdata (w_head[gi]),
        .full  (w_full[gi]),
        .empty (w_empty[gi]),
        .level (w_lvl)
      );

      assign level[LW*gi +: LW] = LW'(w_lvl);
    end
  endgenerate

  // A presented-but-stalled beat keeps its grant so a newly filled channel
  // closer to rr_ptr cannot steal the output before the handshake.
  always_comb begin
    w_grant = r_rr_ptr;
    w_found = 1'b0;
    if (r_state == ARB_LOCK) begin
      w_grant = r_lock_chan;
    end else if (r_held) begin
      w_grant = r_held_chan;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_found && !w_empty[(int'(r_rr_ptr) + i) % CHANNELS]) begin
          w_grant = CW'((int'(r_rr_ptr) + i) % CHANNELS);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_out_valid = !w_empty[w_grant];
  assign w_sel       = entry_t'(w_head[w_grant]);
  assign w_hs        = w_out_valid && out_ready;

  assign out_valid = w_out_valid;
  assign out_kind  = w_out_valid ? w_sel.kind : K_DATA;
  assign out_data  = w_out_valid ? w_sel.data : '0;
  assign out_chan  = w_out_valid ? w_grant : '0;
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_lock_chan <= '0;
      r_held_chan <= '0;
      r_held      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (|w_rsvd_acc) r_err <= 1'b1;
      case (r_state)
        ARB_IDLE: begin
          if (w_hs) begin
            r_held <= 1'b0;
            if (w_sel.kind == K_DATA) begin
              r_state     <= ARB_LOCK;
              r_lock_chan <= w_grant;
            end else begin
              r_rr_ptr <= CW'(wrap_inc(int'(w_grant), CHANNELS));
            end
          end else if (w_out_valid) begin
            r_held      <= 1'b1;
            r_held_chan <= w_grant;
          end
        end
        ARB_LOCK: begin
          // Stored kinds are DATA, LAST or CMD; anything but DATA ends the packet.
          if (w_hs && (w_sel.kind != K_DATA)) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= CW'(wrap_inc(int'(r_lock_chan), CHANNELS));
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_typed_chan_arb_fifo.sv
// Directed bench for typed_chan_arb_fifo: a queue-based reference model checked every
// cycle on the falling edge, plus literal expectations from hand-worked scenarios.
module tb_typed_chan_arb_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CH = 2;
  localparam int CW = 1;
  localparam int LW = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [CH-1:0]      in_valid = '0;
  logic [CH-1:0]      in_ready;
  logic [2*CH-1:0]    in_kind = '0;
  logic [W*CH-1:0]    in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         out_kind;
  logic [W-1:0]       out_data;
  logic [CW-1:0]      out_chan;
  logic [CH*LW-1:0]   level;
  logic               err;

  typed_chan_arb_fifo #(.WIDTH(W), .DEPTH(D), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_kind  (out_kind),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .level     (level),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] k;
    logic [7:0] d;
  } beat_t;

  beat_t      mq [CH][$];
  logic       m_locked;
  int         m_lock;
  int         m_rr;
  logic       m_stalled;
  int         m_stall_ch;
  logic       m_err;
  logic [7:0] out_log [$];

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mq[c].delete();
    m_locked   = 1'b0;
    m_lock     = 0;
    m_rr       = 0;
    m_stalled  = 1'b0;
    m_stall_ch = 0;
    m_err      = 1'b0;
  endtask

  // Reference: the model's queues hold what the channels store; each falling edge
  // predicts the outputs, compares, then applies the next rising edge's effects.
  always @(negedge clk) begin : cmp
    int          ch;
    logic        v;
    logic [CH-1:0]    er;
    logic [CH*LW-1:0] el;
    beat_t       b;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_err", err, 0);
      model_reset();
    end else begin
      er = '0;
      el = '0;
      for (int c = 0; c < CH; c++) begin
        er[c] = (mq[c].size() < D);
        el[c*LW +: LW] = LW'(mq[c].size());
      end
      v  = 1'b0;
      ch = m_rr;
      if (m_locked) begin
        ch = m_lock;
        v  = (mq[ch].size() > 0);
      end else if (m_stalled) begin
        ch = m_stall_ch;
        v  = 1'b1;
      end else begin
        for (int i = 0; i < CH; i++) begin
          if (!v && mq[(m_rr + i) % CH].size() > 0) begin
            ch = (m_rr + i) % CH;
            v  = 1'b1;
          end
        end
      end
      chk("in_ready", in_ready, er);
      chk("level", level, el);
      chk("err", err, m_err);
      chk("out_valid", out_valid, v);
      chk("out_chan", out_chan, v ? ch : 0);
      chk("out_kind", out_kind, v ? mq[ch][0].k : 0);
      chk("out_data", out_data, v ? mq[ch][0].d : 0);
      if (out_valid && out_ready) out_log.push_back(out_data);

      if (v && out_ready) begin
        b = mq[ch].pop_front();
        m_stalled = 1'b0;
        if (!m_locked) begin
          if (b.k == 2'd0) begin
            m_locked = 1'b1;
            m_lock   = ch;
          end else begin
            m_rr = (ch + 1) % CH;
          end
        end else if (b.k != 2'd0) begin
          m_locked = 1'b0;
          m_rr     = (m_lock + 1) % CH;
        end
      end else if (v) begin
        m_stalled  = 1'b1;
        m_stall_ch = ch;
      end
      for (int c = 0; c < CH; c++) begin
        if (in_valid[c] && er[c]) begin
          if (in_kind[2*c +: 2] == 2'd3) m_err = 1'b1;
          else mq[c].push_back({in_kind[2*c +: 2], in_data[8*c +: 8]});
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input int c, input logic [1:0] k, input logic [7:0] d);
    in_valid[c]       = 1'b1;
    in_kind[2*c +: 2] = k;
    in_data[8*c +: 8] = d;
  endtask

  task automatic clr();
    in_valid = '0;
    in_kind  = '0;
    in_data  = '0;
  endtask

  initial begin
    model_reset();
    cyc(2);
    chk("t0_in_ready", in_ready, 0);
    chk("t0_out_valid", out_valid, 0);
    rst = 1'b0;
    cyc(1);

    // Single command beat on ch1
    out_ready = 1'b1;
    put(1, 2'd2, 8'hA5);
    cyc(1);
    clr();
    chk("t1_valid", out_valid, 1);
    chk("t1_chan", out_chan, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_lvl1_full", level[5:3], 1);
    cyc(1);
    chk("t1_lvl1_empty", level[5:3], 0);
    chk("t1_log", out_log.size(), 1);
    out_log.delete();

    // Round-robin alternation between command beats
    out_ready = 1'b0;
    put(0, 2'd2, 8'h11);
    put(1, 2'd2, 8'h21);
    cyc(1);
    clr();
    put(0, 2'd2, 8'h12);
    cyc(1);
    clr();
    out_ready = 1'b1;
    cyc(4);
    chk("t2_cnt", out_log.size(), 3);
    chk("t2_o0", out_log[0], 8'h11);
    chk("t2_o1", out_log[1], 8'h21);
    chk("t2_o2", out_log[2], 8'h12);
    out_log.delete();

    // Packet lock: ch1 must wait while ch0 is momentarily empty mid-packet
    put(0, 2'd0, 8'h01);
    cyc(1);
    clr();
    put(1, 2'd2, 8'h99);
    cyc(1);
    clr();
    chk("t3_gap0", out_valid, 0);
    cyc(1);
    chk("t3_gap1", out_valid, 0);
    put(0, 2'd0, 8'h02);
    cyc(1);
    put(0, 2'd1, 8'h03);
    cyc(1);
    clr();
    cyc(4);
    chk("t3_cnt", out_log.size(), 4);
    chk("t3_o0", out_log[0], 8'h01);
    chk("t3_o1", out_log[1], 8'h02);
    chk("t3_o2", out_log[2], 8'h03);
    chk("t3_o3", out_log[3], 8'h99);
    out_log.delete();

    // Fill ch0 to DEPTH, refuse a fifth beat, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(0, 2'd2, 8'h40 + 8'(i));
      cyc(1);
    end
    clr();
    chk("t4_lvl_full", level[2:0], 4);
    chk("t4_ready0", in_ready[0], 0);
    put(0, 2'd2, 8'h44);
    cyc(1);
    clr();
    chk("t4_lvl_hold", level[2:0], 4);
    out_ready = 1'b1;
    cyc(5);
    chk("t4_cnt", out_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_order", out_log[i], 8'h40 + i);
    chk("t4_lvl_drained", level[2:0], 0);
    out_log.delete();

    // Reserved kind: handshake completes, nothing stored, sticky err
    put(0, 2'd3, 8'h77);
    cyc(1);
    clr();
    chk("t5_err", err, 1);
    chk("t5_lvl0", level[2:0], 0);
    chk("t5_valid", out_valid, 0);
    cyc(3);
    chk("t5_err_sticky", err, 1);

    // Asynchronous reset in the middle of a packet
    out_ready = 1'b0;
    put(0, 2'd0, 8'h31);
    cyc(1);
    put(0, 2'd0, 8'h32);
    cyc(1);
    clr();
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    put(1, 2'd2, 8'h66);
    cyc(1);
    clr();
    chk("t6_pre_level", level, 6'b001_001);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_level", level, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_ready", in_ready, 0);
    cyc(1);
    rst = 1'b0;
    out_log.delete();
    out_ready = 1'b1;
    put(1, 2'd2, 8'h5A);
    cyc(1);
    clr();
    chk("t6_valid", out_valid, 1);
    chk("t6_chan", out_chan, 1);
    chk("t6_data", out_data, 8'h5A);
    cyc(2);
    chk("t6_cnt", out_log.size(), 1);
    chk("t6_o0", out_log[0], 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
